// File: rtl/ram512x16_ctrl_pkg.sv
// Shared constants and types for the 512x16 RAM arbitration controller.
package ram512x16_ctrl_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned DEPTH  = 512;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a conflict the requester not served last wins.
module rr_arb2
    import ram512x16_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_q;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = (last_q == ID_B);
                gnt_b = (last_q == ID_A);
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // Starting from "B last" lets A win the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ID_B;
        end else if (gnt_a) begin
            last_q <= ID_A;
        end else if (gnt_b) begin
            last_q <= ID_B;
        end
    end

endmodule

// File: rtl/ram512x16_arb_ctrl.sv
// Shares one 512x16 RAM between requesters A and B: optional clear walk, round-robin
// command arbitration, registered RAM command and tagged read-data return.
module ram512x16_arb_ctrl
    import ram512x16_ctrl_pkg::*;
#(
    parameter int unsigned       RD_LAT         = 1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL        = 16'h0000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [BE_W-1:0]   a_be,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [BE_W-1:0]   b_be,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_WA,
    output logic [ADDR_W-1:0] ram_RA,
    output logic [DATA_W-1:0] ram_WD,
    output logic [BE_W-1:0]   ram_WEN,
    output logic              ram_WClk_En,
    output logic              ram_RClk_En,
    input  logic [DATA_W-1:0] ram_RD
);

    localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(DEPTH - 1);
    localparam state_e            RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              run;
    logic              acc;
    logic              rd_acc;
    logic              sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic [RD_LAT:0]   pv_q;
    logic [RD_LAT:0]   pid_q;

    assign run = (state_q == S_RUN);

    rr_arb2 u_arb (
        .clk   (Clk),
        .rst   (Rst),
        .en    (run),
        .req_a (a_req),
        .req_b (b_req),
        .gnt_a (a_gnt),
        .gnt_b (b_gnt)
    );

    always_comb begin
        acc       = (a_req & a_gnt) | (b_req & b_gnt);
        sel_id    = (b_req & b_gnt) ? ID_B : ID_A;
        sel_we    = (sel_id == ID_B) ? b_we    : a_we;
        sel_addr  = (sel_id == ID_B) ? b_addr  : a_addr;
        sel_wdata = (sel_id == ID_B) ? b_wdata : a_wdata;
        sel_be    = (sel_id == ID_B) ? b_be    : a_be;
        rd_acc    = acc & ~sel_we;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= RESET_STATE;
            busy        <= CLEAR_ON_RESET;
            clr_addr_q  <= '0;
            ram_WA      <= '0;
            ram_RA      <= '0;
            ram_WD      <= '0;
            ram_WEN     <= '0;
            ram_WClk_En <= 1'b0;
            ram_RClk_En <= 1'b0;
        end else begin
            ram_WEN     <= '0;
            ram_WClk_En <= 1'b0;
            ram_RClk_En <= 1'b0;
            unique case (state_q)
                S_CLEAR: begin
                    ram_WA      <= clr_addr_q;
                    ram_WD      <= CLR_VAL;
                    ram_WEN     <= '1;
                    ram_WClk_En <= 1'b1;
                    clr_addr_q  <= clr_addr_q + 1'b1;
                    if (clr_addr_q == CLR_LAST) begin
                        state_q <= S_RUN;
                        busy    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Addresses and data hold when idle; only the enables drop.
                    if (acc && sel_we) begin
                        ram_WA      <= sel_addr;
                        ram_WD      <= sel_wdata;
                        ram_WEN     <= sel_be;
                        ram_WClk_En <= 1'b1;
                    end else if (acc) begin
                        ram_RA      <= sel_addr;
                        ram_RClk_En <= 1'b1;
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

    // Each read travels RD_LAT+1 stages so its tag lines up with ram_RD.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pv_q     <= '0;
            pid_q    <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            pv_q     <= {pv_q[RD_LAT-1:0], rd_acc};
            pid_q    <= {pid_q[RD_LAT-1:0], sel_id};
            a_rvalid <= pv_q[RD_LAT] & (pid_q[RD_LAT] == ID_A);
            b_rvalid <= pv_q[RD_LAT] & (pid_q[RD_LAT] == ID_B);
            if (pv_q[RD_LAT] && pid_q[RD_LAT] == ID_A) begin
                a_rdata <= ram_RD;
            end
            if (pv_q[RD_LAT] && pid_q[RD_LAT] == ID_B) begin
                b_rdata <= ram_RD;
            end
        end
    end

endmodule

// File: tb/tb_ram512x16_arb_ctrl.sv
// Bench for ram512x16_arb_ctrl: RD_LAT=1 and RD_LAT=2 builds share stimulus, each with a RAM
// model and a queue-based reference model checked every cycle, plus directed literal checks.
module tb_ram512x16_arb_ctrl;

    localparam logic [15:0] CLR = 16'hA5A5;

    typedef struct {
        int          due;
        logic        id;
        logic [15:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [8:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic [1:0]  a_be = '0, b_be = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = g + 1;

        logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy, ram_WClk_En, ram_RClk_En;
        logic [15:0] a_rdata, b_rdata, ram_WD, ram_RD, rd1, rd2;
        logic [8:0]  ram_WA, ram_RA;
        logic [1:0]  ram_WEN;
        logic [15:0] ram [512];

        ram512x16_arb_ctrl #(
            .RD_LAT         (LAT),
            .CLEAR_ON_RESET (1'b1),
            .CLR_VAL        (CLR)
        ) u_dut (
            .Clk         (clk),
            .Rst         (rst),
            .a_req       (a_req),
            .a_we        (a_we),
            .a_addr      (a_addr),
            .a_wdata     (a_wdata),
            .a_be        (a_be),
            .a_gnt       (a_gnt),
            .a_rvalid    (a_rvalid),
            .a_rdata     (a_rdata),
            .b_req       (b_req),
            .b_we        (b_we),
            .b_addr      (b_addr),
            .b_wdata     (b_wdata),
            .b_be        (b_be),
            .b_gnt       (b_gnt),
            .b_rvalid    (b_rvalid),
            .b_rdata     (b_rdata),
            .busy        (busy),
            .ram_WA      (ram_WA),
            .ram_RA      (ram_RA),
            .ram_WD      (ram_WD),
            .ram_WEN     (ram_WEN),
            .ram_WClk_En (ram_WClk_En),
            .ram_RClk_En (ram_RClk_En),
            .ram_RD      (ram_RD)
        );

        // RAM block: acts on the edge after the command is registered.
        always @(posedge clk) begin
            if (ram_WClk_En) begin
                if (ram_WEN[0]) ram[ram_WA][7:0] <= ram_WD[7:0];
                if (ram_WEN[1]) ram[ram_WA][15:8] <= ram_WD[15:8];
            end
            if (ram_RClk_En) rd1 <= ram[ram_RA];
            rd2 <= rd1;
        end
        assign ram_RD = (LAT == 1) ? rd1 : rd2;

        // Reference: array contents, last-served flag, and a queue of reads due by cycle.
        logic [15:0] mdl [512];
        int          clr_left = 512;
        int          mcyc = 0;
        logic        last_b = 1'b1;
        logic        ea_v = 1'b0, eb_v = 1'b0;
        logic [15:0] ea_d = '0, eb_d = '0;
        rd_t         pend[$];

        initial forever begin
            logic        ga, gb, we;
            logic [8:0]  ad;
            logic [15:0] wd, mask;
            rd_t         r;
            @(posedge clk or posedge rst);
            if (rst) begin
                clr_left = 512;
                last_b   = 1'b1;
                pend.delete();
                ea_v = 1'b0; eb_v = 1'b0; ea_d = '0; eb_d = '0;
            end else begin
                mcyc++;
                ea_v = 1'b0;
                eb_v = 1'b0;
                if (pend.size() > 0 && pend[0].due == mcyc) begin
                    if (pend[0].id) begin eb_v = 1'b1; eb_d = pend[0].data; end
                    else begin ea_v = 1'b1; ea_d = pend[0].data; end
                    void'(pend.pop_front());
                end
                if (clr_left > 0) begin
                    clr_left--;
                    if (clr_left == 0) for (int i = 0; i < 512; i++) mdl[i] = CLR;
                end else begin
                    ga = a_req && (!b_req || last_b);
                    gb = b_req && (!a_req || !last_b);
                    if (ga || gb) begin
                        last_b = gb;
                        we   = gb ? b_we : a_we;
                        ad   = gb ? b_addr : a_addr;
                        wd   = gb ? b_wdata : a_wdata;
                        mask = gb ? {{8{b_be[1]}}, {8{b_be[0]}}} : {{8{a_be[1]}}, {8{a_be[0]}}};
                        if (we) begin
                            mdl[ad] = (mdl[ad] & ~mask) | (wd & mask);
                        end else begin
                            r.due  = mcyc + 1 + int'(LAT);
                            r.id   = gb;
                            r.data = mdl[ad];
                            pend.push_back(r);
                        end
                    end
                end
            end
        end

        initial forever begin
            logic xa, xb;
            @(negedge clk);
            xa = (clr_left == 0) && a_req && (!b_req || last_b);
            xb = (clr_left == 0) && b_req && (!a_req || !last_b);
            chk($sformatf("i%0d a_gnt", g), a_gnt, xa);
            chk($sformatf("i%0d b_gnt", g), b_gnt, xb);
            chk($sformatf("i%0d busy", g), busy, clr_left > 0);
            chk($sformatf("i%0d a_rvalid", g), a_rvalid, ea_v);
            chk($sformatf("i%0d b_rvalid", g), b_rvalid, eb_v);
            chk($sformatf("i%0d a_rdata", g), a_rdata, ea_d);
            chk($sformatf("i%0d b_rdata", g), b_rdata, eb_d);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [8:0] ad, input logic [15:0] d, input logic [1:0] be);
        a_req = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = d; a_be = be;
        tick();
        a_req = 1'b0; a_we = 1'b0;
    endtask

    task automatic a_read(input logic [8:0] ad, output logic [15:0] d);
        int n;
        a_req = 1'b1; a_we = 1'b0; a_addr = ad;
        tick();
        a_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_inst[0].a_rvalid && n < 10);
        chk("read return within bound", g_inst[0].a_rvalid, 1'b1);
        d = g_inst[0].a_rdata;
        tick();
    endtask

    task automatic wait_clear(output int n, output int stray);
        n = 0;
        stray = 0;
        @(negedge clk);
        while (g_inst[0].busy && n < 2000) begin
            n++;
            if (g_inst[0].a_rvalid || g_inst[0].b_rvalid ||
                g_inst[1].a_rvalid || g_inst[1].b_rvalid) stray++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n, stray, na, nb;
        logic [15:0] d;
        logic [5:0]  ga_pat, gb_pat;
        logic        exp_v;

        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Clear with A already requesting a read of the top address.
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h1FF;
        wait_clear(n, stray);
        chk("clear busy cycles", n, 512);
        chk("first run cycle a_gnt", g_inst[0].a_gnt, 1'b1);
        tick();
        a_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_inst[0].a_rvalid && n < 10);
        chk("post-clear read latency", n, 3);
        chk("post-clear read data", g_inst[0].a_rdata, 16'hA5A5);
        tick();

        a_write(9'h001, 16'h0101, 2'b11);
        a_write(9'h002, 16'h0202, 2'b11);

        // A write then B read of the same address on the next cycle.
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'h010; a_wdata = 16'h1234; a_be = 2'b11;
        tick();
        a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h010;
        tick();
        b_req = 1'b0;
        na = 0; nb = 0; d = '0;
        repeat (8) begin
            @(negedge clk);
            if (g_inst[0].a_rvalid) na++;
            if (g_inst[0].b_rvalid) begin nb++; d = g_inst[0].b_rdata; end
        end
        tick();
        chk("raw b_rvalid pulses", nb, 1);
        chk("raw b_rdata", d, 16'h1234);
        chk("raw a_rvalid pulses", na, 0);

        // Both requesting for 6 cycles: grants must alternate starting with A.
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h001;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h002;
        ga_pat = '0; gb_pat = '0; na = 0; nb = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 6) begin
                ga_pat = {ga_pat[4:0], g_inst[0].a_gnt};
                gb_pat = {gb_pat[4:0], g_inst[0].b_gnt};
            end
            if (g_inst[0].a_rvalid) begin na++; chk("rr a_rdata", g_inst[0].a_rdata, 16'h0101); end
            if (g_inst[0].b_rvalid) begin nb++; chk("rr b_rdata", g_inst[0].b_rdata, 16'h0202); end
            tick();
            if (c == 5) begin a_req = 1'b0; b_req = 1'b0; end
        end
        chk("rr a_gnt pattern", ga_pat, 6'b101010);
        chk("rr b_gnt pattern", gb_pat, 6'b010101);
        chk("rr a returns", na, 3);
        chk("rr b returns", nb, 3);

        // Byte enables.
        a_write(9'h020, 16'hFFFF, 2'b11);
        a_write(9'h020, 16'h00AB, 2'b01);
        a_read(9'h020, d);
        chk("be=01 merge", d, 16'hFFAB);
        a_write(9'h020, 16'h1234, 2'b00);
        a_read(9'h020, d);
        chk("be=00 no change", d, 16'hFFAB);

        // Continuous reads: RD_LAT=2 build returns 16 in a row from cycle 4.
        for (int i = 0; i < 16; i++) a_write(9'(i), 16'(32'h0100 + i), 2'b11);
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin a_req = 1'b1; a_we = 1'b0; a_addr = 9'(c); end
            else a_req = 1'b0;
            @(negedge clk);
            exp_v = (c >= 4) && (c < 20);
            chk("lat2 a_rvalid", g_inst[1].a_rvalid, exp_v);
            if (exp_v) chk("lat2 a_rdata", g_inst[1].a_rdata, 16'(32'h0100 + c - 4));
            tick();
        end

        // Reset mid-run, then again at cycle 200 of the clear.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (200) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(n, stray);
        chk("restarted clear cycles", n, 512);
        tick();

        // Reset with two reads in flight.
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h001;
        tick();
        a_addr = 9'h002;
        tick();
        a_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(n, stray);
        chk("clear after in-flight reset", n, 512);
        chk("stray rvalid after reset", stray, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
